// File: rtl/neuron_stream_mac_if.sv
// ----------------------------------------------------------------------------
// neuron_stream_mac_if
//   Streaming handshake bundle for one neuron: the activation input stream
//   and the result output stream, each with a valid/ready pair.
//
//   Parameter
//     DATA_W     signed width of activations and result
//
//   Signals
//     in_valid   activation on in_data is valid          (master -> slave)
//     in_ready   neuron accepts in_data this cycle        (slave  -> master)
//     in_data    signed activation, Q(DATA_W-FRAC).FRAC   (master -> slave)
//     out_valid  result is valid                          (slave  -> master)
//     out_ready  downstream accepts the result            (master -> slave)
//     result     signed saturated neuron output           (slave  -> master)
//
//   Modports
//     slave      the neuron side
//     master     the producer/consumer side driving the neuron
// ----------------------------------------------------------------------------
interface neuron_stream_mac_if #(
  parameter int DATA_W = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] result;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result
  );
endinterface

// File: rtl/neuron_stream_mac.sv
// ----------------------------------------------------------------------------
// neuron_stream_mac
//   Sequential fixed-point neuron. It accepts INPUT_SIZE activations, one per
//   accepted beat, multiplies each by the matching weight from an internal
//   ROM and sums the products in a wide accumulator. It then adds the bias,
//   rescales by FRAC_BITS with floor rounding, saturates to DATA_W and
//   presents the result on a valid/ready output.
//   FSM: IDLE -> ACCUM -> BIAS -> OUT -> IDLE.
//
//   Ports
//     clk        rising-edge clock
//     rst_n      synchronous active-low reset
//     start      one-cycle pulse; starts an inference when idle
//     busy       high in every state except IDLE
//     bus        neuron_stream_mac_if.slave (in_valid/in_ready/in_data,
//                out_valid/out_ready/result)
//
//   Parameters
//     INPUT_SIZE   number of beats (weights) per inference
//     DATA_W       signed width of activations, weights, bias and result
//     FRAC_BITS    fractional bits of the shared Q format
//     ACC_W        accumulator width, at least 2*DATA_W+$clog2(INPUT_SIZE)
//     WEIGHT_INIT  weight ROM image, INPUT_SIZE words of DATA_W bits packed
//                  with word 0 in the least significant bits (generated from
//                  the layer's weight .mem image)
//     BIAS         signed bias, same Q format as the data
//
//   Configuration macro
//     NEURON_RELU_EN  when defined, negative results are clamped to zero
//                     (hidden layers); when undefined the signed saturated
//                     value passes through (output layer).
// ----------------------------------------------------------------------------
module neuron_stream_mac #(
  parameter int                           INPUT_SIZE  = 784,
  parameter int                           DATA_W      = 16,
  parameter int                           FRAC_BITS   = 8,
  parameter int                           ACC_W       = 42,
  parameter logic [INPUT_SIZE*DATA_W-1:0] WEIGHT_INIT = '0,
  parameter logic [DATA_W-1:0]            BIAS        = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  neuron_stream_mac_if.slave        bus
);

  localparam int IDX_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int PROD_W = 2 * DATA_W;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(INPUT_SIZE - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

  // Saturation bounds expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // An undersized accumulator could wrap on a full-scale input vector.
  if (ACC_W < 2 * DATA_W + $clog2(INPUT_SIZE)) begin : g_acc_w_check
    $error("neuron_stream_mac: ACC_W is below 2*DATA_W+clog2(INPUT_SIZE)");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_BIAS  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t                     state_r;
  logic signed [ACC_W-1:0]    acc_r;
  logic [IDX_W-1:0]           idx_r;
  logic                       in_ready_r;
  logic                       out_valid_r;
  logic                       busy_r;
  logic signed [DATA_W-1:0]   result_r;

  logic signed [DATA_W-1:0]   weight_rom_s [INPUT_SIZE];
  logic signed [DATA_W-1:0]   weight_s;
  logic signed [PROD_W-1:0]   prod_s;
  logic signed [ACC_W-1:0]    prod_ext_s;
  logic signed [DATA_W-1:0]   result_next_s;
  logic                       beat_s;

  // Bias add, floor rescale, saturation and optional ReLU of the final sum.
  function automatic logic signed [DATA_W-1:0] finish_sum(
    input logic signed [ACC_W-1:0] acc
  );
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  t;
    logic signed [ACC_W-1:0]  s;
    logic signed [DATA_W-1:0] r;
    bias_ext = {{(ACC_W-DATA_W){BIAS[DATA_W-1]}}, BIAS};
    t = acc + (bias_ext <<< FRAC_BITS);
    // Arithmetic shift of a signed value rounds toward minus infinity.
    s = t >>> FRAC_BITS;
    if (s > SAT_MAX) begin
      r = SAT_MAX[DATA_W-1:0];
    end else if (s < SAT_MIN) begin
      r = SAT_MIN[DATA_W-1:0];
    end else begin
      r = s[DATA_W-1:0];
    end
`ifdef NEURON_RELU_EN
    if (r[DATA_W-1]) begin
      r = '0;
    end else begin
      r = r;
    end
`endif
    return r;
  endfunction

  // Unpack the ROM image into addressable words.
  for (genvar g = 0; g < INPUT_SIZE; g++) begin : g_rom
    assign weight_rom_s[g] = WEIGHT_INIT[g*DATA_W +: DATA_W];
  end

  // Asynchronous ROM read, multiply and sign extension for the accumulator.
  always_comb begin
    weight_s      = weight_rom_s[idx_r];
    prod_s        = bus.in_data * weight_s;
    prod_ext_s    = {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
    beat_s        = bus.in_valid && in_ready_r;
    result_next_s = finish_sum(acc_r);
  end

  // Control FSM with registered handshake outputs and datapath state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      acc_r       <= '0;
      idx_r       <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      result_r    <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            acc_r      <= '0;
            idx_r      <= '0;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b1;
            state_r    <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (beat_s) begin
            acc_r <= acc_r + prod_ext_s;
            // The last beat leaves idx at its final value so the ROM
            // address stays in range.
            if (idx_r == IDX_LAST) begin
              in_ready_r <= 1'b0;
              state_r    <= S_BIAS;
            end else begin
              idx_r <= idx_r + IDX_ONE;
            end
          end
        end
        S_BIAS: begin
          result_r    <= result_next_s;
          out_valid_r <= 1'b1;
          state_r     <= S_OUT;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= S_IDLE;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign busy          = busy_r;

endmodule
